// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD counter controller.
//   bcd_digit_t       one packed BCD digit
//   BCD_MAX           largest legal digit value
//   bcd_ctrl_state_t  controller FSM states
//   bcd_clamp()       saturate an out-of-range nibble to 9
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} bcd_ctrl_state_t;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the cascaded BCD counter.
//   clock, reset  system clock, async active-low reset
//   ena           count-tick enable (digit advances when also carry_in)
//   load, clr     preset from load_digit / force to zero (clr wins)
//   carry_in      all lower digits are 9 (tie high for digit 0)
//   digit         registered digit value
//   digit_next    value this digit takes on the next increment
//   carry_out     this digit rolls over on the next increment
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic       load,
  input  logic       clr,
  input  bcd_digit_t load_digit,
  input  logic       carry_in,
  output bcd_digit_t digit,
  output bcd_digit_t digit_next,
  output logic       carry_out
);

  assign carry_out  = carry_in && (digit == BCD_MAX);
  // Exposed so the top can compare the post-increment value against target
  // before the edge at which it is committed.
  assign digit_next = carry_in ? ((digit == BCD_MAX) ? 4'd0 : digit + 4'd1) : digit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    digit <= '0;
    else if (clr)  digit <= '0;
    else if (load) digit <= load_digit;
    else if (ena)  digit <= digit_next;
  end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Sequencing controller for a cascaded multi-digit BCD up-counter.
//   clock, reset      system clock, async active-low reset
//   start/stop        run / pause control (stop masks start while running)
//   clear/load        zero or preset the count and return to IDLE
//   load_value        packed BCD preset, nibbles >9 clamp to 9
//   target_en/target  stop in DONE when an increment lands on target
//   count_bcd         current count, digit i at [4i+3:4i]
//   running           high while in RUN
//   done, wrap        one-cycle pulses: target reached / all-9s rollover
module bcd_count_ctrl
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    target_en,
  input  logic [4*NUM_DIGITS-1:0] target,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    running,
  output logic                    done,
  output logic                    wrap
);

  localparam int PW = $clog2(TICK_DIV);

  bcd_ctrl_state_t state;
  logic [PW-1:0]   presc;

  logic                             tick;
  logic                             cnt_clr;
  logic                             cnt_ld;
  logic                             cnt_inc;
  logic                             match;
  logic [NUM_DIGITS:0]              carry;
  logic [NUM_DIGITS-1:0][3:0]       digits;
  logic [NUM_DIGITS-1:0][3:0]       digits_next;

  assign tick = (state == RUN) && (presc == PW'(TICK_DIV - 1));

  // Command decode for the digit array. A restart out of DONE zeroes the
  // count; clear/load on the same cycle as a tick discard the increment.
  assign cnt_clr = clear || (!load && state == DONE && start);
  assign cnt_ld  = !clear && load;
  assign cnt_inc = tick && !clear && !load;

  // Digit 0 always sees a carry so digits_next is the incremented value.
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clock      (clock),
      .reset      (reset),
      .ena        (cnt_inc),
      .load       (cnt_ld),
      .clr        (cnt_clr),
      .load_digit (bcd_clamp(load_value[4*g +: 4])),
      .carry_in   (carry[g]),
      .digit      (digits[g]),
      .digit_next (digits_next[g]),
      .carry_out  (carry[g+1])
    );
  end

  assign count_bcd = digits;
  assign match     = target_en && (digits_next == target);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (clear || load) begin
        state   <= IDLE;
        presc   <= '0;
        running <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            presc <= tick ? '0 : presc + PW'(1);
            // carry out of the top digit means every digit was 9
            if (tick && carry[NUM_DIGITS]) wrap <= 1'b1;
            if (tick && match) begin
              state   <= DONE;
              done    <= 1'b1;
              running <= 1'b0;
            end else if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          IDLE: if (start) begin
            state   <= RUN;
            presc   <= '0;
            running <= 1'b1;
          end
          PAUSE: if (start) begin
            // prescaler phase is kept across a pause
            state   <= RUN;
            running <= 1'b1;
          end
          DONE: if (start) begin
            state   <= RUN;
            presc   <= '0;
            running <= 1'b1;
          end
          default: begin
            state   <= IDLE;
            presc   <= '0;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
